u_rec_ctrl: RTL and testbench

U_REC_CTRL -- requirements
Module: u_rec_ctrl

---
 rtl/u_rec_ctrl_pkg.sv | 21 ++
 rtl/u_rec_strobe.sv | 35 +++
 rtl/u_rec_ctrl.sv | 150 +++++++++++++++
 tb/tb_u_rec_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/u_rec_ctrl_pkg.sv
// Shared constants and types for the packet receive controller.
package u_rec_ctrl_pkg;

  localparam logic [7:0]  DefSyncByte = 8'hA5;
  localparam int          DefMaxLen   = 8;
  localparam logic [7:0]  DefMinLow   = 8'd100;
  localparam logic [15:0] DefTimeout  = 16'd4000;

  typedef enum logic [1:0] {
    Idle    = 2'd0,
    Len     = 2'd1,
    Payload = 2'd2,
    Csum    = 2'd3
  } recState_e;

  // A length byte is usable when it is non-zero and fits the payload buffer.
  function automatic logic lenOk(input logic [7:0] lenByte, input logic [7:0] maxLen);
    return (lenByte != 8'd0) && (lenByte <= maxLen);
  endfunction

endpackage

// File: rtl/u_rec_strobe.sv
// Byte strobe qualifier: a rising edge on the receiver ready level only counts
// as a byte when the line was low long enough beforehand, so glitches and the
// level already high out of reset never look like a byte.
module u_rec_strobe
  import u_rec_ctrl_pkg::*;
#(
  parameter logic [7:0] MIN_LOW = DefMinLow
) (
  input  logic sys_clk,
  input  logic sys_rst_l,
  input  logic byte_readyH,
  output logic strobe
);

  logic [7:0] lowCnt;
  logic       prevReady;

  // Track the previous ready level and how long the line has been low (saturating).
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      lowCnt    <= 8'd0;
      prevReady <= 1'b0;
    end else begin
      prevReady <= byte_readyH;
      if (byte_readyH) begin
        lowCnt <= 8'd0;
      end else if (lowCnt != 8'hFF) begin
        lowCnt <= lowCnt + 8'd1;
      end
    end
  end

  assign strobe = byte_readyH && !prevReady && (lowCnt >= MIN_LOW);

endmodule

// File: rtl/u_rec_ctrl.sv
// Packet receive controller: frames SYNC / length / payload / checksum bytes
// from the byte receiver, holds one committed packet in a small register
// buffer and lets the host drain it one byte per pop.
module u_rec_ctrl
  import u_rec_ctrl_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE = DefSyncByte,
  parameter int          MAX_LEN   = DefMaxLen,
  parameter logic [7:0]  MIN_LOW   = DefMinLow,
  parameter logic [15:0] TIMEOUT   = DefTimeout
) (
  input  logic       sys_clk,
  input  logic       sys_rst_l,
  input  logic [7:0] byte_dataH,
  input  logic       byte_readyH,
  input  logic       pkt_popH,
  output logic       pkt_availH,
  output logic [3:0] pkt_lenH,
  output logic [7:0] pkt_dataH,
  output logic       busyH,
  output logic       err_csumH,
  output logic       err_lenH,
  output logic       err_toH,
  output logic       err_ovrH
);

  localparam int         PtrW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MaxLenByte = 8'(MAX_LEN);

  logic        strobe;
  logic        strobeD;
  logic [7:0]  dataD;
  recState_e   state;
  logic [3:0]  length;
  logic [7:0]  csum;
  logic [3:0]  wrCount;
  logic [3:0]  rdCount;
  logic [15:0] toCnt;
  logic [7:0]  buffer [MAX_LEN];

  u_rec_strobe #(
    .MIN_LOW(MIN_LOW)
  ) strobeGen (
    .sys_clk    (sys_clk),
    .sys_rst_l  (sys_rst_l),
    .byte_readyH(byte_readyH),
    .strobe     (strobe)
  );

  // Capture the byte together with its strobe; the parser acts on this copy one cycle later.
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      strobeD <= 1'b0;
      dataD   <= 8'd0;
    end else begin
      strobeD <= strobe;
      dataD   <= byte_dataH;
    end
  end

  // Parser FSM, payload buffer, inter-byte timeout and host read side; all outputs registered.
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      state      <= Idle;
      length     <= 4'd0;
      csum       <= 8'd0;
      wrCount    <= 4'd0;
      rdCount    <= 4'd0;
      toCnt      <= 16'd0;
      pkt_availH <= 1'b0;
      pkt_lenH   <= 4'd0;
      err_csumH  <= 1'b0;
      err_lenH   <= 1'b0;
      err_toH    <= 1'b0;
      err_ovrH   <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        buffer[i] <= 8'd0;
      end
    end else begin
      err_csumH <= 1'b0;
      err_lenH  <= 1'b0;
      err_toH   <= 1'b0;
      err_ovrH  <= 1'b0;

      if (pkt_popH && pkt_availH) begin
        if (rdCount == pkt_lenH - 4'd1) begin
          pkt_availH <= 1'b0;
          rdCount    <= 4'd0;
        end else begin
          rdCount <= rdCount + 4'd1;
        end
      end

      if (state == Idle) begin
        toCnt <= 16'd0;
        if (strobeD && (dataD == SYNC_BYTE)) begin
          if (pkt_availH) begin
            err_ovrH <= 1'b1;
          end else begin
            state <= Len;
          end
        end
      end else if (strobeD) begin
        toCnt <= 16'd0;
        case (state)
          Len: begin
            if (lenOk(dataD, MaxLenByte)) begin
              length  <= dataD[3:0];
              csum    <= dataD;
              wrCount <= 4'd0;
              state   <= Payload;
            end else begin
              err_lenH <= 1'b1;
              state    <= Idle;
            end
          end
          Payload: begin
            buffer[wrCount[PtrW-1:0]] <= dataD;
            csum    <= csum ^ dataD;
            wrCount <= wrCount + 4'd1;
            if (wrCount + 4'd1 == length) begin
              state <= Csum;
            end
          end
          Csum: begin
            if (dataD == csum) begin
              pkt_availH <= 1'b1;
              pkt_lenH   <= length;
              rdCount    <= 4'd0;
            end else begin
              err_csumH <= 1'b1;
            end
            state <= Idle;
          end
          default: state <= Idle;
        endcase
      end else if (toCnt == TIMEOUT - 16'd1) begin
        err_toH <= 1'b1;
        toCnt   <= 16'd0;
        state   <= Idle;
      end else begin
        toCnt <= toCnt + 16'd1;
      end
    end
  end

  assign busyH     = (state != Idle);
  assign pkt_dataH = buffer[rdCount[PtrW-1:0]];

endmodule

// File: tb/tb_u_rec_ctrl.sv
// Testbench for u_rec_ctrl: directed packets with hand-computed expectations,
// then randomized traffic checked every cycle against a packet-level model.
module tb_u_rec_ctrl;

  localparam logic [7:0] SyncByte = 8'hA5;
  localparam int         MaxLen   = 8;
  localparam int         MinLow   = 100;
  localparam int         Timeout  = 4000;

  typedef logic [7:0] byteQ_t [$];

  logic       sys_clk     = 1'b0;
  logic       sys_rst_l   = 1'b0;
  logic [7:0] byte_dataH  = SyncByte;
  logic       byte_readyH = 1'b1;
  logic       pkt_popH    = 1'b0;
  logic       pkt_availH;
  logic [3:0] pkt_lenH;
  logic [7:0] pkt_dataH;
  logic       busyH;
  logic       err_csumH;
  logic       err_lenH;
  logic       err_toH;
  logic       err_ovrH;

  int total = 0;
  int bad   = 0;
  bit randPop = 1'b0;
  int csumPulses = 0;
  int lenPulses  = 0;
  int toPulses   = 0;
  int ovrPulses  = 0;
  byteQ_t seq;

  // Packet-level model state
  bit         mAvail = 1'b0;
  logic [3:0] mLen = 4'd0;
  logic [7:0] mQ [$];
  bit         mCollect = 1'b0;
  logic [7:0] mBytes [$];
  int         mIdle = 0;
  bit         mPend = 1'b0;
  logic [7:0] mPendByte = 8'd0;
  bit         mPrevRdy = 1'b0;
  int         mLowRun = 0;
  bit         mErrCsum = 1'b0;
  bit         mErrLen  = 1'b0;
  bit         mErrTo   = 1'b0;
  bit         mErrOvr  = 1'b0;

  u_rec_ctrl #(
    .SYNC_BYTE(SyncByte),
    .MAX_LEN  (MaxLen),
    .MIN_LOW  (8'(MinLow)),
    .TIMEOUT  (16'(Timeout))
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_l  (sys_rst_l),
    .byte_dataH (byte_dataH),
    .byte_readyH(byte_readyH),
    .pkt_popH   (pkt_popH),
    .pkt_availH (pkt_availH),
    .pkt_lenH   (pkt_lenH),
    .pkt_dataH  (pkt_dataH),
    .busyH      (busyH),
    .err_csumH  (err_csumH),
    .err_lenH   (err_lenH),
    .err_toH    (err_toH),
    .err_ovrH   (err_ovrH)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One accepted byte applied to the packet rules: SYNC opens a packet unless one
  // is still waiting, then length, payload and an XOR checksum over length+payload.
  task automatic modelByte(input logic [7:0] b, input bit availBefore);
    logic [7:0] x;
    if (!mCollect) begin
      if (b == SyncByte) begin
        if (availBefore) begin
          mErrOvr = 1'b1;
        end else begin
          mCollect = 1'b1;
          mBytes.delete();
          mIdle = 0;
        end
      end
    end else begin
      mIdle = 0;
      mBytes.push_back(b);
      if (mBytes.size() == 1) begin
        if (b == 8'd0 || int'(b) > MaxLen) begin
          mErrLen  = 1'b1;
          mCollect = 1'b0;
        end
      end else if (mBytes.size() == int'(mBytes[0]) + 2) begin
        x = 8'd0;
        for (int i = 0; i < mBytes.size() - 1; i++) x = x ^ mBytes[i];
        if (x == b) begin
          mQ.delete();
          for (int i = 1; i < mBytes.size() - 1; i++) mQ.push_back(mBytes[i]);
          mAvail = 1'b1;
          mLen   = mBytes[0][3:0];
        end else begin
          mErrCsum = 1'b1;
        end
        mCollect = 1'b0;
      end
    end
  endtask

  // Model update at every clock edge (or asynchronously on reset)
  initial forever begin
    bit availBefore;
    bit rise;
    @(posedge sys_clk or negedge sys_rst_l);
    if (!sys_rst_l) begin
      mAvail = 1'b0; mLen = 4'd0; mQ.delete(); mCollect = 1'b0; mBytes.delete();
      mIdle = 0; mPend = 1'b0; mPendByte = 8'd0; mPrevRdy = 1'b0; mLowRun = 0;
      mErrCsum = 1'b0; mErrLen = 1'b0; mErrTo = 1'b0; mErrOvr = 1'b0;
    end else begin
      rise = byte_readyH && !mPrevRdy && (mLowRun >= MinLow);
      availBefore = mAvail;
      mErrCsum = 1'b0; mErrLen = 1'b0; mErrTo = 1'b0; mErrOvr = 1'b0;
      if (pkt_popH && mAvail) begin
        void'(mQ.pop_front());
        if (mQ.size() == 0) mAvail = 1'b0;
      end
      if (mPend) begin
        modelByte(mPendByte, availBefore);
      end else if (mCollect) begin
        mIdle++;
        if (mIdle == Timeout) begin
          mErrTo   = 1'b1;
          mCollect = 1'b0;
        end
      end
      mPend     = rise;
      mPendByte = byte_dataH;
      if (byte_readyH) mLowRun = 0;
      else mLowRun++;
      mPrevRdy = byte_readyH;
    end
  end

  // Compare DUT against the model mid-cycle, and count error pulses
  initial forever begin
    @(negedge sys_clk);
    if (err_csumH) csumPulses++;
    if (err_lenH)  lenPulses++;
    if (err_toH)   toPulses++;
    if (err_ovrH)  ovrPulses++;
    checkOutput("avail",   16'(pkt_availH), 16'(mAvail));
    checkOutput("busy",    16'(busyH),      16'(mCollect));
    checkOutput("errCsum", 16'(err_csumH),  16'(mErrCsum));
    checkOutput("errLen",  16'(err_lenH),   16'(mErrLen));
    checkOutput("errTo",   16'(err_toH),    16'(mErrTo));
    checkOutput("errOvr",  16'(err_ovrH),   16'(mErrOvr));
    if (mAvail) begin
      checkOutput("len",  16'(pkt_lenH),  16'(mLen));
      checkOutput("data", 16'(pkt_dataH), 16'(mQ[0]));
    end
  end

  task automatic tick();
    @(negedge sys_clk);
    pkt_popH = randPop && ($urandom_range(0, 3) == 0);
  endtask

  task automatic applyStimulus(input logic [7:0] b, input int lowCycles);
    byte_readyH = 1'b0;
    repeat (lowCycles) tick();
    byte_dataH  = b;
    byte_readyH = 1'b1;
    repeat (3) tick();
  endtask

  task automatic sendSeq(input byteQ_t q);
    foreach (q[i]) applyStimulus(q[i], MinLow + int'($urandom_range(0, 15)));
  endtask

  task automatic popOne();
    pkt_popH = 1'b1;
    tick();
  endtask

  task automatic applyReset(input int cycles);
    @(posedge sys_clk);
    #2 sys_rst_l = 1'b0;
    repeat (cycles) tick();
  endtask

  task automatic releaseReset();
    @(posedge sys_clk);
    #2 sys_rst_l = 1'b1;
    tick();
  endtask

  initial begin
    int c0;
    int kind;
    int len;
    logic [7:0] cs;
    logic [7:0] b;

    // Reset values, then release with ready already high carrying SYNC
    repeat (3) tick();
    checkOutput("rstAvail", 16'(pkt_availH), 16'h0);
    checkOutput("rstLen",   16'(pkt_lenH),   16'h0);
    checkOutput("rstData",  16'(pkt_dataH),  16'h0);
    checkOutput("rstBusy",  16'(busyH),      16'h0);
    releaseReset();
    repeat (4) tick();
    checkOutput("noStrobeAfterReset", 16'(busyH), 16'h0);

    // Good packet: checksum 03^11^22^33 = 03
    seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    sendSeq(seq);
    checkOutput("goodAvail", 16'(pkt_availH), 16'h1);
    checkOutput("goodLen",   16'(pkt_lenH),   16'h3);
    checkOutput("goodData0", 16'(pkt_dataH),  16'h11);
    popOne();
    checkOutput("goodData1", 16'(pkt_dataH),  16'h22);
    popOne();
    checkOutput("goodData2", 16'(pkt_dataH),  16'h33);
    checkOutput("goodAvail2", 16'(pkt_availH), 16'h1);
    popOne();
    checkOutput("drainedAvail", 16'(pkt_availH), 16'h0);

    // Same packet with a wrong checksum
    c0 = csumPulses;
    seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00};
    sendSeq(seq);
    checkOutput("csumPulses", 16'(csumPulses - c0), 16'h1);
    checkOutput("csumAvail",  16'(pkt_availH),      16'h0);
    checkOutput("csumBusy",   16'(busyH),           16'h0);

    // Length 0 and MaxLen+1
    c0 = lenPulses;
    seq = '{8'hA5, 8'h00};
    sendSeq(seq);
    seq = '{8'hA5, 8'h09};
    sendSeq(seq);
    checkOutput("lenPulses", 16'(lenPulses - c0), 16'h2);
    checkOutput("lenBusy",   16'(busyH),          16'h0);

    // Low-time boundary and false start
    applyStimulus(SyncByte, 6);
    checkOutput("falseStartBusy", 16'(busyH), 16'h0);
    applyStimulus(SyncByte, MinLow - 1);
    checkOutput("shortLowBusy", 16'(busyH), 16'h0);
    applyStimulus(SyncByte, MinLow);
    checkOutput("exactLowBusy", 16'(busyH), 16'h1);

    // Timeout after A5,02,44: pulse exactly Timeout cycles after the last byte is processed
    c0 = toPulses;
    applyStimulus(8'h02, MinLow);
    applyStimulus(8'h44, MinLow);
    repeat (Timeout - 2) tick();
    checkOutput("toBefore", 16'(err_toH), 16'h0);
    tick();
    checkOutput("toPulse", 16'(err_toH), 16'h1);
    tick();
    checkOutput("toAfter",  16'(err_toH), 16'h0);
    checkOutput("toBusy",   16'(busyH),   16'h0);
    checkOutput("toPulses", 16'(toPulses - c0), 16'h1);
    seq = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
    sendSeq(seq);
    checkOutput("postToAvail", 16'(pkt_availH), 16'h1);
    checkOutput("postToData",  16'(pkt_dataH),  16'h7E);
    popOne();
    checkOutput("postToDrain", 16'(pkt_availH), 16'h0);

    // Overrun: second SYNC while a packet waits
    seq = '{8'hA5, 8'h02, 8'hAA, 8'hBB, 8'h13};
    sendSeq(seq);
    c0 = ovrPulses;
    applyStimulus(SyncByte, MinLow + 3);
    checkOutput("ovrPulses", 16'(ovrPulses - c0), 16'h1);
    checkOutput("ovrBusy",   16'(busyH),          16'h0);
    checkOutput("ovrData0",  16'(pkt_dataH),      16'hAA);
    popOne();
    checkOutput("ovrData1",  16'(pkt_dataH),      16'hBB);
    popOne();
    checkOutput("ovrDrain",  16'(pkt_availH),     16'h0);

    // Reset with a committed packet waiting
    seq = '{8'hA5, 8'h01, 8'h55, 8'h54};
    sendSeq(seq);
    checkOutput("preRstAvail", 16'(pkt_availH), 16'h1);
    byte_dataH = SyncByte;
    applyReset(3);
    checkOutput("midRstAvail", 16'(pkt_availH), 16'h0);
    checkOutput("midRstData",  16'(pkt_dataH),  16'h0);
    checkOutput("midRstLen",   16'(pkt_lenH),   16'h0);
    releaseReset();
    repeat (3) tick();
    checkOutput("midRstBusy", 16'(busyH), 16'h0);

    // Randomized traffic with random host pops
    randPop = 1'b1;
    for (int n = 0; n < 35; n++) begin
      kind = int'($urandom_range(0, 9));
      if (kind == 0) begin
        applyStimulus(8'($urandom_range(0, 255)), int'($urandom_range(2, MinLow + 10)));
      end else if (kind == 1) begin
        b = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MaxLen + 1, 255));
        seq = '{SyncByte, b};
        sendSeq(seq);
      end else begin
        len = int'($urandom_range(1, MaxLen));
        seq = '{SyncByte, 8'(len)};
        cs = 8'(len);
        for (int i = 0; i < len; i++) begin
          b = 8'($urandom_range(0, 255));
          seq.push_back(b);
          cs = cs ^ b;
        end
        if (kind == 2) cs = cs ^ 8'($urandom_range(1, 255));
        seq.push_back(cs);
        sendSeq(seq);
      end
    end
    randPop = 1'b0;
    repeat (20) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
